paddle_controller: RTL
======================

Name: paddle_controller

Overview:
- Produces the vertical position of one paddle (y_pad), consumed by the ball controller and the paddle renderer.
- Driven by two player buttons, up and down, sampled on the frame-rate timing_tick.
- Motion is accelerating and clamped to the play field.
- The paddle is held at the field centre whenever the game is not in the play state; one instance exists per player.

Parameters:
- SCREEN_H, vga_pkg::VER_PIXELS, visible field height in pixels
- PAD_HEIGHT, 145, paddle height in pixels
- EDGE_MARGIN, 4, minimum gap in pixels between the paddle and the top/bottom field edge
- MIN_VEL, 2, pixels per tick on the first tick of motion
- MAX_VEL, 6, velocity ceiling in pixels per tick
- ACCEL_TICKS, 16, number of moving ticks in one direction before velocity increments by 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- timing_tick  in  1  one-cycle pulse per frame; all motion happens only on this pulse
- state  in  2  game state (vga_pkg state encoding); motion is enabled only when state == play
- btn_up  in  1  asynchronous, active-high "up" button
- btn_down  in  1  asynchronous, active-high "down" button
- y_ball  in  10  ball top y; used only with PADDLE_AI_EN
- ai_mode  in  1  selects AI control; ignored without PADDLE_AI_EN
- y_pad  out  10  paddle top y
- pad_moving  out  1  high while the FSM is in MOVE_UP or MOVE_DOWN

Behaviour:
- Constants:
  - Y_MIN = EDGE_MARGIN
  - Y_MAX = SCREEN_H - PAD_HEIGHT - EDGE_MARGIN
  - Y_CTR = (SCREEN_H - PAD_HEIGHT)/2
- Reset and non-play: when rst = 1 or state != play, on the next edge:
  - y_pad = Y_CTR
  - FSM = IDLE
  - vel = MIN_VEL
  - hold_cnt = 0
  - pad_moving = 0
  - Button synchronizers are cleared only by rst.
- Button synchronization: each button passes through a 2-flop synchronizer, so decision latency is 2 clk cycles from a button edge.
- Direction decode from the synchronized buttons:
  - up only -> UP
  - down only -> DOWN
  - both pressed or neither pressed -> NONE
- FSM states: IDLE, MOVE_UP, MOVE_DOWN. The FSM, y_pad, vel and hold_cnt change only on cycles where timing_tick = 1 (and play, not rst).
- On a tick, by direction:
  - NONE: FSM -> IDLE, vel = MIN_VEL, hold_cnt = 0, y_pad unchanged.
  - Direction differs from the current state (including from IDLE and on reversal):
    - move by MIN_VEL
    - FSM -> matching MOVE state
    - vel = MIN_VEL
    - hold_cnt = 1
  - Direction equals the current state:
    - move by the current vel
    - if hold_cnt == ACCEL_TICKS-1: vel = min(vel+1, MAX_VEL) and hold_cnt = 0
    - otherwise hold_cnt++
- Position arithmetic: performed in 11 bits, with no wrap.
  - Up: y_pad = (y_pad < Y_MIN + step) ? Y_MIN : y_pad - step.
  - Down: y_pad = (y_pad + step > Y_MAX) ? Y_MAX : y_pad + step.
  - At a clamp the FSM stays in its MOVE state and vel keeps ramping; y_pad is simply held at the limit.
- Output latency: y_pad and pad_moving are registered and update on the same edge that samples the tick.
- state leaving play mid-motion: forces the centre values on the next edge, regardless of timing_tick.

Optional Feature:
- Macro PADDLE_AI_EN.
- Defined, with ai_mode = 1:
  - Buttons are ignored.
  - Direction = UP if y_ball + 7 < y_pad + PAD_HEIGHT/2 - 8.
  - Direction = DOWN if y_ball + 7 > y_pad + PAD_HEIGHT/2 + 8.
  - Otherwise direction = NONE (16-pixel dead zone).
  - The FSM, ramp and clamp logic are reused unchanged.
- Not defined: ai_mode and y_ball are unconnected internally and there is no AI logic.

Decomposition:
- vga_pkg (existing): VER_PIXELS and the game state enum.
- New pong_pkg:
  - PAD_HEIGHT, EDGE_MARGIN and velocity defaults
  - paddle FSM enum {IDLE, MOVE_UP, MOVE_DOWN}
  - direction enum {NONE, UP, DOWN}
- One sub-module, btn_sync: 2-flop synchronizer, instantiated once per button.

Test Plan:
All cases use SCREEN_H=768, so Y_CTR=311, Y_MIN=4, Y_MAX=619.
- Reset: rst pulse -> y_pad=311 and pad_moving=0 on the next edge; both hold with buttons released over 10 ticks.
- Basic motion: btn_up held, 5 ticks after sync -> y_pad=301, pad_moving=1; release then 1 tick -> IDLE, y_pad stays 301.
- Acceleration: btn_down held from 311 -> ticks 1-16 move 2 each (y_pad=343); tick 17 moves 3 (346); after 32 more ticks vel=5.
- Clamp: btn_down held until saturation -> y_pad never exceeds 619 and stays at 619; btn_up from 5 -> next tick y_pad=4.
- Simultaneous buttons and reversal: both buttons pressed while moving -> no motion, vel reset; down->up reversal -> the first up tick moves exactly 2.
- State change and AI: state leaves play mid-motion without a tick -> y_pad=311 next edge. With PADDLE_AI_EN, ai_mode=1, y_pad=311, y_ball=100 -> y_pad decreases by 2 on the next tick.

Source files
------------

// File: rtl/pong_pkg.sv
// Pong gameplay constants plus the paddle FSM and direction encodings.
package pong_pkg;
    localparam int PAD_HEIGHT  = 145;
    localparam int EDGE_MARGIN = 4;
    localparam int MIN_VEL     = 2;
    localparam int MAX_VEL     = 6;
    localparam int ACCEL_TICKS = 16;

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} pad_fsm_t;
    typedef enum logic [1:0] {NONE, UP, DOWN} dir_t;
endpackage

// File: rtl/vga_pkg.sv
// Shared VGA/game definitions: visible field height and the game state encoding.
package vga_pkg;
    localparam int VER_PIXELS = 768;

    typedef enum logic [1:0] {
        START = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } game_state_t;
endpackage

// File: rtl/paddle_controller_if.sv
// Paddle controller bus: frame tick, game state, player/AI inputs and paddle position.
interface paddle_controller_if;
    import vga_pkg::*;

    logic        timing_tick;
    game_state_t state;
    logic        btn_up;
    logic        btn_down;
    logic [9:0]  y_ball;
    logic        ai_mode;
    logic [9:0]  y_pad;
    logic        pad_moving;

    modport master (output timing_tick, state, btn_up, btn_down, y_ball, ai_mode,
                    input  y_pad, pad_moving);
    modport slave  (input  timing_tick, state, btn_up, btn_down, y_ball, ai_mode,
                    output y_pad, pad_moving);
endinterface

// File: rtl/paddle_controller_btn_sync.sv
// Two-flop synchronizer for one asynchronous push button; cleared only by rst.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/paddle_controller.sv
// One player's paddle: accelerating, clamped motion on the frame tick, centred outside play.
// Optional PADDLE_AI_EN macro adds ball-tracking control selected by ai_mode.
module paddle_controller
    import vga_pkg::*;
    import pong_pkg::*;
#(
    parameter int SCREEN_H    = vga_pkg::VER_PIXELS,
    parameter int PAD_HEIGHT  = pong_pkg::PAD_HEIGHT,
    parameter int EDGE_MARGIN = pong_pkg::EDGE_MARGIN,
    parameter int MIN_VEL     = pong_pkg::MIN_VEL,
    parameter int MAX_VEL     = pong_pkg::MAX_VEL,
    parameter int ACCEL_TICKS = pong_pkg::ACCEL_TICKS
) (
    input logic           clk,
    input logic           rst,
    paddle_controller_if.slave bus
);
    localparam logic [10:0] Y_MIN     = 11'(EDGE_MARGIN);
    localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - PAD_HEIGHT - EDGE_MARGIN);
    localparam logic [10:0] Y_CTR     = 11'((SCREEN_H - PAD_HEIGHT) / 2);
    localparam logic [3:0]  V_MIN     = 4'(MIN_VEL);
    localparam logic [3:0]  V_MAX     = 4'(MAX_VEL);
    localparam logic [7:0]  HOLD_LAST = 8'(ACCEL_TICKS - 1);

    logic        up_s, down_s;
    dir_t        dir;
    pad_fsm_t    fsm_q, fsm_d;
    logic [9:0]  y_q, y_d;
    logic [3:0]  vel_q, vel_d, step;
    logic [7:0]  hold_q, hold_d;
    logic        mov_q;
    logic        same_dir;
    logic [10:0] y_n;

    btn_sync u_sync_up   (.clk(clk), .rst(rst), .d(bus.btn_up),   .q(up_s));
    btn_sync u_sync_down (.clk(clk), .rst(rst), .d(bus.btn_down), .q(down_s));

`ifdef PADDLE_AI_EN
    logic [10:0] ball_c, pad_c;
    assign ball_c = {1'b0, bus.y_ball} + 11'd7;
    assign pad_c  = {1'b0, y_q} + 11'(PAD_HEIGHT / 2);
`endif

    always_comb begin
        dir = NONE;
`ifdef PADDLE_AI_EN
        if (bus.ai_mode) begin
            // Dead zone of +/-8 around the paddle centre; +8 on the left avoids underflow.
            if (ball_c + 11'd8 < pad_c)      dir = UP;
            else if (ball_c > pad_c + 11'd8) dir = DOWN;
        end else begin
`else
        begin
`endif
            if (up_s && !down_s)      dir = UP;
            else if (down_s && !up_s) dir = DOWN;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        y_d      = y_q;
        vel_d    = vel_q;
        hold_d   = hold_q;
        step     = V_MIN;
        y_n      = {1'b0, y_q};
        same_dir = (dir == UP && fsm_q == MOVE_UP) || (dir == DOWN && fsm_q == MOVE_DOWN);
        if (bus.timing_tick) begin
            if (dir == NONE) begin
                fsm_d  = IDLE;
                vel_d  = V_MIN;
                hold_d = 8'd0;
            end else begin
                if (same_dir) begin
                    step = vel_q;
                    if (hold_q == HOLD_LAST) begin
                        vel_d  = (vel_q >= V_MAX) ? V_MAX : 4'(vel_q + 4'd1);
                        hold_d = 8'd0;
                    end else begin
                        hold_d = 8'(hold_q + 8'd1);
                    end
                end else begin
                    fsm_d  = (dir == UP) ? MOVE_UP : MOVE_DOWN;
                    vel_d  = V_MIN;
                    hold_d = 8'd1;
                end
                // 11-bit math so neither the subtract nor the add can wrap before clamping.
                if (dir == UP)
                    y_n = ({1'b0, y_q} < Y_MIN + {7'd0, step}) ? Y_MIN : {1'b0, y_q} - {7'd0, step};
                else
                    y_n = ({1'b0, y_q} + {7'd0, step} > Y_MAX) ? Y_MAX : {1'b0, y_q} + {7'd0, step};
                y_d = y_n[9:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.state != PLAY) begin
            fsm_q  <= IDLE;
            y_q    <= Y_CTR[9:0];
            vel_q  <= V_MIN;
            hold_q <= 8'd0;
            mov_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            y_q    <= y_d;
            vel_q  <= vel_d;
            hold_q <= hold_d;
            mov_q  <= (fsm_d != IDLE);
        end
    end

    assign bus.y_pad      = y_q;
    assign bus.pad_moving = mov_q;
endmodule
